// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
// Serialises 24-bit GRB pixel words from a valid/ready stream into the
// single-wire WS2812 waveform, including inter-pixel hand-off, the
// end-of-frame latch gap and the mid-frame starvation timeout.
// Optional feature macro: WS2812_RGB_INPUT_EN (input words are RGB and are
// reordered to GRB as they enter the holding register).
module ws2812_bit_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_PER    = 20,
    parameter int T0H        = 400,
    parameter int T1H        = 800,
    parameter int TBIT       = 1250,
    parameter int TRES       = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_last,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  led_data_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int T0H_CYC  = T0H / CLK_PER;
    localparam int T1H_CYC  = T1H / CLK_PER;
    localparam int TBIT_CYC = TBIT / CLK_PER;
    localparam int TRES_CYC = TRES / CLK_PER;
    localparam int CW       = $clog2(TRES_CYC + 1);

    localparam logic [CW-1:0] T0H_LAST  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T1H_LAST  = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] TRES_LAST = CW'(TRES_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_WAIT,
        S_LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   shift_q, shift_d;
    logic          cur_last_q, cur_last_d;
    logic [23:0]   hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_valid_q, hold_valid_d;
    logic          led_q;
    logic          fd_pend_q, fd_pend_d;
    logic          ur_pend_q, ur_pend_d;
    logic          frame_done_q, underrun_q;
    logic          accept, load;
    logic [23:0]   pix_grb;
    logic [CW-1:0] hi_last;

`ifdef WS2812_RGB_INPUT_EN
    assign pix_grb = {pix_data[15:8], pix_data[23:16], pix_data[7:0]};
`else
    assign pix_grb = pix_data[23:0];
`endif

    generate
        if (DATA_WIDTH > 24) begin : g_upper
            logic pix_upper_unused;
            assign pix_upper_unused = ^pix_data[DATA_WIDTH-1:24];
        end
    endgenerate

    assign accept       = pix_valid && !hold_valid_q;
    assign hi_last      = shift_q[23] ? T1H_LAST : T0H_LAST;
    assign pix_ready    = !hold_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign led_data_out = led_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;

    // Next-state logic: bit timing, pixel hand-off, latch and starvation timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        cur_last_d  = cur_last_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        fd_pend_d   = 1'b0;
        ur_pend_d   = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end
            end
            S_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == hi_last) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == TBIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q != 5'd23) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                        state_d = S_HIGH;
                    end else if (hold_valid_q) begin
                        load    = 1'b1;
                        state_d = S_HIGH;
                    end else if (cur_last_q) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == TRES_LAST) begin
                    ur_pend_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == TRES_LAST) begin
                    fd_pend_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Loading the shifter empties the hold; accepting fills it. Accept
        // requires an empty hold and load a full one, so they never coincide.
        if (load) begin
            shift_d    = hold_data_q;
            cur_last_d = hold_last_q;
            bit_d      = 5'd0;
        end
        if (accept) begin
            hold_data_d = pix_grb;
            hold_last_d = pix_last;
        end
        hold_valid_d = (hold_valid_q && !load) || accept;
    end

    // Control state with synchronous reset; the line follows the FSM one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 5'd0;
            cur_last_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            led_q        <= 1'b0;
            fd_pend_q    <= 1'b0;
            ur_pend_q    <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            cur_last_q   <= cur_last_d;
            hold_valid_q <= hold_valid_d;
            led_q        <= (state_q == S_HIGH);
            fd_pend_q    <= fd_pend_d;
            ur_pend_q    <= ur_pend_d;
            frame_done_q <= fd_pend_q;
            underrun_q   <= ur_pend_q;
        end
    end

    // Pixel datapath registers; their contents only matter once qualified by control.
    always_ff @(posedge clk) begin
        shift_q     <= shift_d;
        hold_data_q <= hold_data_d;
        hold_last_q <= hold_last_d;
    end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Testbench for ws2812_bit_encoder: decodes the line waveform into bits,
// high times and rise-to-rise periods, and compares against hand-computed values.
module tb_ws2812_bit_encoder;

    localparam int PERIOD_CYC = 62;
    localparam int HI1_CYC    = 40;
    localparam int HI0_CYC    = 20;
    localparam int LAST_RISE_TO_PULSE = 62 + 2500;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pix_data;
    logic        pix_last;
    logic        pix_valid;
    logic        pix_ready;
    logic        led_data_out;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    ws2812_bit_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .led_data_out (led_data_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Line decoder: records rise cycles, high lengths and pulse events.
    int rise_q[$];
    int hi_q[$];
    int cyc = 0;
    int hl = 0;
    logic led_prev = 1'b0;
    int fd_n = 0, ur_n = 0, both_n = 0;
    int fd_cyc = 0, ur_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (led_data_out && !led_prev) begin
            rise_q.push_back(cyc);
            hl <= 1;
        end else if (led_data_out) begin
            hl <= hl + 1;
        end
        if (!led_data_out && led_prev) hi_q.push_back(hl);
        if (frame_done) begin
            fd_n   <= fd_n + 1;
            fd_cyc <= cyc;
        end
        if (underrun) begin
            ur_n   <= ur_n + 1;
            ur_cyc <= cyc;
        end
        if (frame_done && underrun) both_n <= both_n + 1;
        led_prev <= led_data_out;
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        pix_data  = d;
        pix_last  = last;
        pix_valid = 1'b1;
        while (!pix_ready && n < 6000) begin
            tick();
            n++;
        end
        chk("send_ready", pix_ready, 1);
        @(posedge clk);
        tick();
        pix_valid = 1'b0;
        pix_data  = 32'hDEAD_BEEF;
        pix_last  = 1'b0;
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rise_q.size() < target && n < 6000) begin
            tick();
            n++;
        end
        chk("wait_rises", rise_q.size() >= target, 1);
    endtask

    task automatic wait_fd(input int target);
        int n = 0;
        while (fd_n < target && n < 8000) begin
            tick();
            n++;
        end
        chk("wait_frame_done", fd_n >= target, 1);
    endtask

    task automatic wait_ur(input int target);
        int n = 0;
        while (ur_n < target && n < 8000) begin
            tick();
            n++;
        end
        chk("wait_underrun", ur_n >= target, 1);
    endtask

    // Decode npix pixels starting at rise index br / high index bh.
    task automatic check_stream(input string name, input int br, input int bh,
                                input int npix, input logic [47:0] exp, input int tot);
        int nb;
        int badh;
        int badp;
        logic [47:0] got;
        nb   = npix * 24;
        badh = 0;
        badp = 0;
        got  = '0;
        chk({name, "_rises"}, rise_q.size() - br, tot);
        if (rise_q.size() >= br + nb && hi_q.size() >= bh + nb) begin
            for (int i = 0; i < nb; i++) begin
                if (hi_q[bh+i] == HI1_CYC)      got = {got[46:0], 1'b1};
                else if (hi_q[bh+i] == HI0_CYC) got = {got[46:0], 1'b0};
                else begin
                    got = {got[46:0], 1'b0};
                    badh++;
                end
            end
            for (int i = 0; i < nb - 1; i++)
                if (rise_q[br+i+1] - rise_q[br+i] != PERIOD_CYC) badp++;
            chk({name, "_bits"}, got, exp);
            chk({name, "_bad_highs"}, badh, 0);
            chk({name, "_bad_periods"}, badp, 0);
        end
    endtask

    function automatic logic [23:0] wire_order(input logic [23:0] v);
`ifdef WS2812_RGB_INPUT_EN
        return {v[15:8], v[23:16], v[7:0]};
`else
        return v;
`endif
    endfunction

    typedef struct {
        logic [31:0] pix;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic single_frame(input string name, input logic [31:0] pix, input logic [23:0] exp);
        int br, bh, f0, u0;
        br = rise_q.size();
        bh = hi_q.size();
        f0 = fd_n;
        u0 = ur_n;
        send(pix, 1'b1);
        wait_fd(f0 + 1);
        repeat (3) tick();
        check_stream(name, br, bh, 1, {24'h0, exp}, 24);
        if (rise_q.size() >= br + 24)
            chk({name, "_latch_gap"}, fd_cyc - rise_q[br+23], LAST_RISE_TO_PULSE);
        chk({name, "_frame_done_cnt"}, fd_n - f0, 1);
        chk({name, "_underrun_cnt"}, ur_n - u0, 0);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int br, bh, f0, u0;

        vecs[0] = '{pix: 32'h00A5_00FF, exp: 24'hA500FF};
        vecs[1] = '{pix: 32'h0000_0000, exp: 24'h000000};
        vecs[2] = '{pix: 32'h00FF_FFFF, exp: 24'hFFFFFF};
        vecs[3] = '{pix: 32'h1234_5678, exp: 24'h345678};
        vecs[4] = '{pix: 32'hFF80_0001, exp: 24'h800001};

        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_last  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_led", led_data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", pix_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);

        // Table-driven single-pixel frames
        for (int i = 0; i < 5; i++)
            single_frame($sformatf("vec%0d", i), vecs[i].pix, wire_order(vecs[i].exp));

        // Two back-to-back pixels, second held during the first
        br = rise_q.size(); bh = hi_q.size(); f0 = fd_n; u0 = ur_n;
        send(32'h0000_00FF, 1'b0);
        send(32'h00FF_0000, 1'b1);
        tick();
        chk("two_ready_while_held", pix_ready, 0);
        wait_rises(br + 25);
        tick();
        chk("two_ready_after_load", pix_ready, 1);
        wait_fd(f0 + 1);
        repeat (3) tick();
        check_stream("two", br, bh, 2,
                     {wire_order(24'h0000FF), wire_order(24'hFF0000)}, 48);
        chk("two_frame_done_cnt", fd_n - f0, 1);
        chk("two_underrun_cnt", ur_n - u0, 0);

        // Starvation mid-frame
        br = rise_q.size(); bh = hi_q.size(); f0 = fd_n; u0 = ur_n;
        send(32'h0000_0001, 1'b0);
        wait_ur(u0 + 1);
        repeat (3) tick();
        check_stream("starve", br, bh, 1, {24'h0, wire_order(24'h000001)}, 24);
        if (rise_q.size() >= br + 24)
            chk("starve_gap", ur_cyc - rise_q[br+23], LAST_RISE_TO_PULSE);
        chk("starve_underrun_cnt", ur_n - u0, 1);
        chk("starve_frame_done_cnt", fd_n - f0, 0);
        chk("starve_busy", busy, 0);

        // Next pixel arrives around WAIT cycle 1000
        br = rise_q.size(); bh = hi_q.size(); f0 = fd_n; u0 = ur_n;
        send(32'h0000_0001, 1'b0);
        wait_rises(br + 24);
        repeat (PERIOD_CYC + 1000) tick();
        chk("resume_busy_in_wait", busy, 1);
        send(32'h00F0_F0F0, 1'b1);
        wait_fd(f0 + 1);
        repeat (3) tick();
        check_stream("resume_a", br, bh, 1, {24'h0, wire_order(24'h000001)}, 48);
        check_stream("resume_b", br + 24, bh + 24, 1, {24'h0, wire_order(24'hF0F0F0)}, 24);
        chk("resume_underrun_cnt", ur_n - u0, 0);
        chk("resume_frame_done_cnt", fd_n - f0, 1);

        // Reset during the high phase of bit 5 with a pixel held
        br = rise_q.size(); f0 = fd_n; u0 = ur_n;
        send(32'h00FF_FFFF, 1'b1);
        send(32'h00AA_AAAA, 1'b1);
        wait_rises(br + 6);
        chk("rst_mid_line_high", led_data_out, 1);
        chk("rst_mid_ready_before", pix_ready, 0);
        reset = 1'b1;
        tick();
        chk("rst_mid_led", led_data_out, 0);
        chk("rst_mid_ready", pix_ready, 1);
        chk("rst_mid_busy", busy, 0);
        reset = 1'b0;
        repeat (3000) tick();
        chk("rst_mid_no_more_rises", rise_q.size() - br, 6);
        chk("rst_mid_frame_done_cnt", fd_n - f0, 0);
        chk("rst_mid_underrun_cnt", ur_n - u0, 0);
        single_frame("after_rst", 32'h005A_5A5A, wire_order(24'h5A5A5A));

`ifdef WS2812_RGB_INPUT_EN
        single_frame("rgb", 32'h0011_2233, 24'h221133);
`endif

        chk("pulses_never_together", both_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812_bit_encoder.md
# ws2812_bit_encoder

Serialises 24-bit pixel words into the single-wire WS2812 waveform that drives the LED strip on PMOD4. It is the stage directly downstream of `led_driver`: `led_driver` fetches pixel words from `mem` over Wishbone and pushes them here over a valid/ready stream. This block owns all bit-level timing, the inter-pixel hand-off and the end-of-frame latch (reset) gap.

## Interface
Parameters:
- `DATA_WIDTH`, 32: pixel word width. Only bits [23:0] are used; the rest are ignored.
- `CLK_PER`, 20: clock period in ns.
- `T0H`, 400: ns high time for a 0 bit.
- `T1H`, 800: ns high time for a 1 bit.
- `TBIT`, 1250: ns total bit period.
- `TRES`, 50000: ns low time for the latch / underrun timeout.
- Derived cycle counts use integer division: `T0H_CYC=T0H/CLK_PER`, and likewise for `T1H`, `TBIT` and `TRES`. Defaults give 20 / 40 / 62 / 2500.
- Required: `1 ≤ T0H_CYC < T1H_CYC < TBIT_CYC`. Counter width is `$clog2(TRES_CYC+1)`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `pix_data`  in  DATA_WIDTH  pixel word, GRB in [23:0], MSB first on the wire.
- `pix_last`  in  1  marks the final pixel of a frame.
- `pix_valid`  in  1  upstream has a word.
- `pix_ready`  out  1  holding register empty; equals `!hold_valid`.
- `led_data_out`  out  1  registered WS2812 line.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of the latch gap.
- `underrun`  out  1  one-cycle pulse when the stream starves mid-frame.

## Operation
- Datapath:
  - One-entry holding register (`hold_data`, `hold_last`, `hold_valid`) feeds a 24-bit shift register.
  - A handshake (`pix_valid && pix_ready`) loads the holding register.
- States: IDLE, HIGH, LOW, WAIT, LATCH.
- IDLE: line low. If `hold_valid`, load the shift register and `cur_last` from the holding register, clear `hold_valid`, go to HIGH.
- HIGH: line high for `T1H_CYC` cycles if shift[23]=1, else `T0H_CYC` cycles, then go to LOW.
- LOW: line low for the remaining cycles up to `TBIT_CYC` total for the bit. At bit end:
  - bits remaining: shift left, go to HIGH;
  - bit 23 done and `hold_valid`: load the next pixel, go to HIGH with no gap;
  - bit 23 done, no held pixel, `cur_last`=1: go to LATCH;
  - otherwise: go to WAIT.
- WAIT: line low, counter runs.
  - `hold_valid` before `TRES_CYC` cycles elapse: load it, go to HIGH.
  - Timeout: pulse `underrun`, go to IDLE. No `frame_done`.
- LATCH: line low for `TRES_CYC` cycles, pulse `frame_done`, go to IDLE. `pix_ready` stays live, so the next frame's first pixel may be held during LATCH. It is not sent before LATCH ends.
- Reset values: `led_data_out`=0, `busy`=0, `frame_done`=0, `underrun`=0, `hold_valid`=0 (so `pix_ready`=1), state IDLE.

## Timing
- Handshake at edge N: `led_data_out` rises at edge N+2 when starting from IDLE.
- Each bit period is exactly `TBIT_CYC` cycles, measured rising edge to rising edge. High phases are exactly `T0H_CYC` or `T1H_CYC` cycles.
- Pixel-to-pixel: zero extra cycles when the next pixel is held before bit 23 ends.
- `pix_ready` is purely `!hold_valid`. A word consumed at edge M re-asserts ready from cycle M+1. Load and accept cannot occur in the same cycle.
- `frame_done` and `underrun` are high for exactly one cycle and never together.
- Reset mid-bit: at the reset edge the line goes low, any held pixel is discarded, and no `frame_done` is produced.
- `pix_last` is sampled only with its handshake. `pix_data` is don't-care while `pix_valid`=0.

## Configuration
- `WS2812_RGB_INPUT_EN`:
  - Defined: `pix_data[23:0]` is interpreted as RGB and reordered to GRB ({[15:8],[23:16],[7:0]}) when the holding register is loaded.
  - Undefined: `pix_data[23:0]` is already GRB and is passed unchanged.
  - No timing difference either way.

## Test plan
All scenarios use default parameters.
- Single pixel 0x00A500FF, `pix_last`=1 (macro undefined):
  - 24 bits, periods 62 cycles each, highs 40 for 1-bits and 20 for 0-bits, pattern 10100101 00000000 11111111;
  - then 2500 low cycles, then `frame_done` pulses once.
- Two pixels 0x000000FF then 0x00FF0000 (last), second presented during the first pixel:
  - 48 contiguous bit periods with no gap;
  - `pix_ready` low only while the hold is full;
  - one `frame_done`.
- Pixel 0x00000001 with `pix_last`=0 and no follow-up: line low 2500 cycles after the last bit, `underrun` pulses, no `frame_done`, `busy` drops.
- Same as above but the next pixel is presented at WAIT cycle 1000: transmission resumes with no `underrun`.
- `reset` asserted during the HIGH phase of bit 5:
  - line low on the next edge, `pix_ready`=1, no pulses;
  - a new pixel afterwards transmits normally.
- With `WS2812_RGB_INPUT_EN` defined, input 0x00112233: wire bit order is 0x221133.
